// File: rtl/crc5_t.sv
// Token/handshake/data packet serializer to the phy byte stream, with a USB-style CRC5 on tokens.
// Optional macro CRC5_T_ERR_INJECT_EN adds crc5_err_inject to corrupt one CRC5 bit per token.
module crc5_t (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_pid_en,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_addr,
  input  logic [3:0] tx_endp,
  input  logic       tx_sop,
  input  logic       tx_eop,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_lp_sop,
  output logic       tx_lp_eop,
  output logic       tx_lp_valid,
  output logic [7:0] tx_lp_data,
  input  logic       tx_lp_ready,
  output logic       tx_busy,
`ifdef CRC5_T_ERR_INJECT_EN
  input  logic       crc5_err_inject,
`endif
  output logic       tx_done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PID  = 3'd1;
  localparam logic [2:0] ST_TOK1 = 3'd2;
  localparam logic [2:0] ST_TOK2 = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic [4:0] crc_rem;
  logic [4:0] crc_field;
  logic       unused_sop;

  assign unused_sop = tx_sop;

  // Bit-serial LFSR unrolled over addr[0..6], endp[0..3]; preset all ones.
  function automatic logic [4:0] crc5_calc(input logic [10:0] din);
    logic [4:0] c;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      c = {c[3:0], 1'b0} ^ ((din[i] ^ c[4]) ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  assign crc_rem   = crc5_calc({endp_q, addr_q});
  // Field goes out bit-reversed: remainder MSB lands on tx_lp_data[3].
  assign crc_field = {~crc_rem[0] ^ err_q, ~crc_rem[1], ~crc_rem[2], ~crc_rem[3], ~crc_rem[4]};

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    err_d       = err_q;
    done_d      = 1'b0;
    tx_lp_valid = 1'b0;
    tx_lp_sop   = 1'b0;
    tx_lp_eop   = 1'b0;
    tx_lp_data  = 8'h00;
    tx_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_pid_en) begin
          state_d = ST_PID;
          pid_d   = tx_pid;
          addr_d  = tx_addr;
          endp_d  = tx_endp;
`ifdef CRC5_T_ERR_INJECT_EN
          err_d   = crc5_err_inject;
`else
          err_d   = 1'b0;
`endif
        end
      end
      ST_PID: begin
        tx_lp_valid = 1'b1;
        tx_lp_sop   = 1'b1;
        tx_lp_eop   = ~pid_q[0];
        tx_lp_data  = {~pid_q, pid_q};
        if (tx_lp_ready) begin
          case (pid_q[1:0])
            2'b01:   state_d = ST_TOK1;
            2'b11:   state_d = ST_DATA;
            default: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      ST_TOK1: begin
        tx_lp_valid = 1'b1;
        tx_lp_data  = {endp_q[0], addr_q};
        if (tx_lp_ready) state_d = ST_TOK2;
      end
      ST_TOK2: begin
        tx_lp_valid = 1'b1;
        tx_lp_eop   = 1'b1;
        tx_lp_data  = {crc_field, endp_q[3:1]};
        if (tx_lp_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_DATA: begin
        tx_lp_valid = tx_valid;
        tx_lp_eop   = tx_eop;
        tx_lp_data  = tx_data;
        tx_ready    = tx_lp_ready;
        if (tx_valid && tx_lp_ready && tx_eop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pid_q   <= 4'h0;
      addr_q  <= 7'h00;
      endp_q  <= 4'h0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign tx_busy = (state_q != ST_IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_crc5_t.sv
// Randomized bench for crc5_t: byte stream scoreboard built from the packet format rules.
module tb_crc5_t;
  logic       clk = 1'b0;
  logic       rst_n, tx_pid_en;
  logic [3:0] tx_pid, tx_endp;
  logic [6:0] tx_addr;
  logic       tx_sop, tx_eop, tx_valid, tx_ready;
  logic [7:0] tx_data, tx_lp_data;
  logic       tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_ready, tx_busy, tx_done;
  logic       err_drv;
`ifdef CRC5_T_ERR_INJECT_EN
  logic       crc5_err_inject;
  assign crc5_err_inject = err_drv;
`endif

  always #5 clk = ~clk;

  crc5_t dut (
    .clk(clk), .rst_n(rst_n), .tx_pid_en(tx_pid_en), .tx_pid(tx_pid), .tx_addr(tx_addr),
    .tx_endp(tx_endp), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_lp_sop(tx_lp_sop), .tx_lp_eop(tx_lp_eop), .tx_lp_valid(tx_lp_valid),
    .tx_lp_data(tx_lp_data), .tx_lp_ready(tx_lp_ready), .tx_busy(tx_busy),
`ifdef CRC5_T_ERR_INJECT_EN
    .crc5_err_inject(crc5_err_inject),
`endif
    .tx_done(tx_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [9:0] exp_q[$];   // {sop, eop, data}
  logic [8:0] up_q[$];    // {eop, data}
  logic [7:0] pay[$];
  int  ready_mode = 2;    // 0 random, 1 ready one cycle in four, 2 always ready
  int  eop_cnt = 0;
  int  cyc = 0;
  bit  up_xfer = 0, in_data = 0, prev_eop = 0, prev_rst = 0, hold_vld = 0;
  logic [9:0] hold_val;

  // Expected CRC5 field as it appears in tx_lp_data[7:3] (index 0 = bit 3).
  function automatic logic [4:0] crc_field(input logic [6:0] addr, input logic [3:0] endp, input bit err);
    int bits, rem, fb;
    logic [4:0] f;
    bits = {21'd0, endp, addr};
    rem = 31;
    for (int i = 0; i < 11; i++) begin
      fb  = ((bits >> i) & 1) ^ ((rem >> 4) & 1);
      rem = ((rem << 1) & 31) ^ (fb != 0 ? 5 : 0);
    end
    rem = ~rem & 31;
    for (int k = 0; k < 5; k++) f[k] = ((rem >> (4 - k)) & 1) != 0;
`ifdef CRC5_T_ERR_INJECT_EN
    if (err) f[4] = ~f[4];
`else
    if (err) f = f;
`endif
    return f;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Output monitor and scoreboard, sampled on the falling edge.
  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    if (prev_eop && prev_rst) begin
      check("done_pulse", tx_done, 1);
      check("busy_after_eop", tx_busy, 0);
    end else begin
      check("done_quiet", tx_done, 0);
    end
    check("tx_ready", tx_ready, in_data && tx_lp_ready);
    if (hold_vld) check("stall_hold", {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, {1'b1, hold_val});
    prev_eop = 0;
    if (tx_lp_valid && tx_lp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", tx_lp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("byte", {tx_lp_sop, tx_lp_eop, tx_lp_data}, e);
        if (e[9] && e[1:0] == 2'b11) in_data = 1;
        if (e[8]) in_data = 0;
      end
      if (tx_lp_eop) begin
        prev_eop = 1;
        eop_cnt++;
      end
    end
    up_xfer  = tx_valid && tx_ready;
    hold_vld = tx_lp_valid && !tx_lp_ready;
    hold_val = {tx_lp_sop, tx_lp_eop, tx_lp_data};
    prev_rst = rst_n;
    if (!rst_n) begin
      exp_q.delete();
      up_q.delete();
      in_data  = 0;
      hold_vld = 0;
      prev_eop = 0;
    end
  end

  // Upstream payload source and phy ready pattern.
  initial forever begin
    bit x;
    @(posedge clk);
    #1;
    x = up_xfer;
    up_xfer = 0;
    if (x && up_q.size() > 0) void'(up_q.pop_front());
    if (!(tx_valid && !x && up_q.size() > 0)) begin
      if (up_q.size() > 0 && $urandom_range(3) != 0) begin
        tx_valid = 1'b1;
        {tx_eop, tx_data} = up_q[0];
      end else begin
        tx_valid = 1'b0;
        tx_eop   = $urandom_range(1);
        tx_data  = $urandom;
      end
    end
    tx_sop = $urandom_range(1);
    case (ready_mode)
      0:       tx_lp_ready = $urandom_range(1);
      1:       tx_lp_ready = (cyc % 4 == 3);
      default: tx_lp_ready = 1'b1;
    endcase
  end

  task automatic push_expected(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp, input bit err);
    exp_q.push_back({1'b1, pid[0] == 1'b0, ~pid, pid});
    if (pid[1:0] == 2'b01) begin
      exp_q.push_back({2'b00, endp[0], addr});
      exp_q.push_back({2'b01, crc_field(addr, endp, err), endp[3:1]});
    end else if (pid[1:0] == 2'b11) begin
      for (int i = 0; i < pay.size(); i++) begin
        up_q.push_back({i == pay.size() - 1, pay[i]});
        exp_q.push_back({1'b0, i == pay.size() - 1, pay[i]});
      end
    end
  endtask

  // Launches one packet in the current cycle and returns at the start of the tx_done cycle.
  task automatic send(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                      input bit err, input int lat_exp);
    int start, c;
    push_expected(pid, addr, endp, err);
    start = eop_cnt;
    tx_pid_en = 1'b1; tx_pid = pid; tx_addr = addr; tx_endp = endp; err_drv = err;
    cycle();
    tx_pid = $urandom; tx_addr = $urandom; tx_endp = $urandom; err_drv = $urandom_range(1);
    @(negedge clk);
    check("pid_latency", {tx_lp_valid, tx_lp_sop}, 2'b11);
    cycle();
    tx_pid_en = 1'b0;
    c = 2;
    while (eop_cnt == start && c < 400) begin
      cycle();
      c++;
    end
    check("pkt_complete", eop_cnt - start, 1);
    if (lat_exp > 0) check("pkt_latency", c, lat_exp);
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, tx_lp_valid, 0);
    check({tag, "_sop"},   tx_lp_sop, 0);
    check({tag, "_eop"},   tx_lp_eop, 0);
    check({tag, "_data"},  tx_lp_data, 0);
    check({tag, "_ready"}, tx_ready, 0);
    check({tag, "_busy"},  tx_busy, 0);
    check({tag, "_done"},  tx_done, 0);
  endtask

  initial begin
    logic [3:0] p;
    rst_n = 1'b0; tx_pid_en = 1'b0; tx_pid = 4'h0; tx_addr = 7'h0; tx_endp = 4'h0; err_drv = 1'b0;
    tx_sop = 1'b0; tx_eop = 1'b0; tx_valid = 1'b0; tx_data = 8'h0; tx_lp_ready = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    check_idle("reset");
    cycle();
    rst_n = 1'b1;
    cycle();

    ready_mode = 2;
    send(4'b1101, 7'h00, 4'h0, 1'b0, 4);          // SETUP: 2D 00 10
    send(4'b0010, 7'h00, 4'h0, 1'b0, 2);          // ACK: D2 alone
    send(4'b0001, 7'h3a, 4'hb, 1'b0, 4);          // OUT with nonzero fields
    ready_mode = 1;
    send(4'b1001, 7'h00, 4'h0, 1'b0, 0);          // IN under stall
    ready_mode = 0;
    pay.delete(); pay.push_back(8'hAA); pay.push_back(8'h55);
    send(4'b0011, 7'h00, 4'h0, 1'b0, 0);          // DATA0
`ifdef CRC5_T_ERR_INJECT_EN
    ready_mode = 2;
    send(4'b1101, 7'h00, 4'h0, 1'b1, 4);          // corrupted CRC5: third byte 90
`endif

    // Reset while the TOK1 byte is on the bus.
    ready_mode = 2;
    cycle();
    push_expected(4'b0001, 7'h15, 4'h6, 1'b0);
    tx_pid_en = 1'b1; tx_pid = 4'b0001; tx_addr = 7'h15; tx_endp = 4'h6;
    cycle();
    tx_pid_en = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    @(negedge clk);
    check_idle("midpkt_reset");
    cycle();
    rst_n = 1'b1;
    cycle();
    send(4'b0001, 7'h00, 4'h0, 1'b0, 4);          // OUT: E1 00 10

    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(2);
      p = $urandom;
      pay.delete();
      for (int i = 0; i < $urandom_range(6, 1); i++) pay.push_back($urandom);
      send(p, $urandom, $urandom, $urandom_range(1), 0);
    end
    repeat (4) cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/crc5_t.md
CRC5_T -- requirements
Module: crc5_t

Interface
REQ-001 clk  input  1  clock; all logic on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 tx_pid_en  input  1  one-cycle packet request from link_control.
REQ-004 tx_pid  input  4  PID to send; sampled with tx_pid_en.
REQ-005 tx_addr  input  7  token address; sampled with tx_pid_en.
REQ-006 tx_endp  input  4  token endpoint; sampled with tx_pid_en.
REQ-007 tx_sop/tx_eop/tx_valid  input  1 each  payload stream from crc16_t (payload bytes plus CRC16); tx_sop ignored.
REQ-008 tx_data  input  8  payload byte from crc16_t.
REQ-009 tx_ready  output  1  payload accept to crc16_t.
REQ-010 tx_lp_sop/tx_lp_eop/tx_lp_valid  output  1 each  byte stream to phy.
REQ-011 tx_lp_data  output  8  byte to phy.
REQ-012 tx_lp_ready  input  1  phy accept.
REQ-013 tx_busy  output  1  high whenever state != IDLE.
REQ-014 tx_done  output  1  one-cycle pulse, cycle after last byte handshake.

Function
REQ-015 Byte transfer occurs on a cycle with tx_lp_valid && tx_lp_ready; tx_lp_valid, tx_lp_data, tx_lp_sop and tx_lp_eop SHALL hold stable until that transfer.
REQ-016 States: IDLE, PID, TOK1, TOK2, DATA.
REQ-017 IDLE: tx_pid_en latches pid/addr/endp and moves to PID next cycle; tx_pid_en outside IDLE SHALL be ignored.
REQ-018 PID: tx_lp_data = {~pid, pid}, tx_lp_sop = 1.
REQ-019 On PID transfer: pid[1:0]=01 (token) -> TOK1; pid[1:0]=11 (data) -> DATA; otherwise (handshake/special) tx_lp_eop = 1 on the PID byte and return to IDLE.
REQ-020 TOK1: tx_lp_data = {endp[0], addr[6:0]}; on transfer -> TOK2.
REQ-021 TOK2: tx_lp_data[2:0] = endp[3:1], [7:3] = CRC5 field; tx_lp_eop = 1; on transfer -> IDLE.
REQ-022 CRC5: polynomial x^5+x^2+1, register preset 5'b11111, 11 bits addr[0]..addr[6], endp[0]..endp[3] fed LSB-first; field = one's complement of remainder, remainder MSB placed at tx_lp_data[3], LSB at tx_lp_data[7].
REQ-023 CRC5 SHALL be computed combinationally from latched fields; it adds no latency.
REQ-024 DATA: tx_lp_valid = tx_valid, tx_lp_data = tx_data, tx_lp_eop = tx_eop, tx_lp_sop = 0, tx_ready = tx_lp_ready; transfer with tx_eop -> IDLE.
REQ-025 tx_ready SHALL be 0 in all states except DATA.
REQ-026 Minimum latency: tx_pid_en in cycle N -> PID byte valid in cycle N+1; with phy always ready a token completes in 3 cycles after PID valid.
REQ-027 tx_done SHALL pulse once per packet, in the cycle after the eop transfer; a new tx_pid_en in that same cycle is accepted.

Reset
REQ-028 rst_n low: state IDLE; tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_ready, tx_busy, tx_done = 0; tx_lp_data and latched fields = 0.
REQ-029 Reset mid-packet SHALL abort immediately with no eop issued; the next request starts a fresh packet.

Configuration
REQ-030 Macro CRC5_T_ERR_INJECT_EN defined: adds input crc5_err_inject (1 bit, sampled with tx_pid_en); when set, CRC5 field bit tx_lp_data[7] SHALL be inverted for that token.
REQ-031 Macro undefined: no crc5_err_inject port; CRC5 field always correct.

Verification
REQ-032 SETUP addr 0x00 endp 0x0, phy always ready -> bytes 0x2D(sop), 0x00, 0x10(eop); tx_done next cycle.
REQ-033 ACK (pid 0010) -> single byte 0xD2 with sop and eop both set; state IDLE after transfer.
REQ-034 IN addr 0x00 endp 0x0 with tx_lp_ready low 3 cycles per byte -> byte 0x69 and following bytes held stable throughout stall; no duplicated or dropped byte.
REQ-035 DATA0 (pid 0011) with upstream 0xAA, 0x55(eop) -> 0xC3(sop), 0xAA, 0x55(eop); tx_ready low until after PID transfer.
REQ-036 rst_n low during TOK1 -> all outputs zero next cycle; subsequent OUT addr 0x00 endp 0x0 emits 0xE1, 0x00, 0x10.
REQ-037 With CRC5_T_ERR_INJECT_EN and crc5_err_inject = 1, SETUP addr 0x00 endp 0x0 -> third byte 0x90.
